// File: rtl/ldtu_sample_packer.sv
// LiTe-DTU sample packer: packs baseline runs into 6-bit fields and signal samples into 13-bit
// fields, then buffers the 32-bit words in a small output FIFO with a valid/ready handshake.
module ldtu_sample_packer #(
    parameter int unsigned OFIFO_DEPTH = 4,
    parameter int unsigned OFIFO_AW    = 2
) (
    input  logic                CLK,
    input  logic                rst_b,
    input  logic [12:0]         DATA_to_enc,
    input  logic                baseline_flag,
    output logic [31:0]         DATA32,
    output logic                DATA32_valid,
    input  logic                DATA32_ready,
    output logic [OFIFO_AW:0]   fifo_level,
    output logic                fifo_overflow
);

    typedef enum logic [2:0] {
        StEmpty = 3'd0,
        StBase1 = 3'd1,
        StBase2 = 3'd2,
        StBase3 = 3'd3,
        StBase4 = 3'd4,
        StSig1  = 3'd5
    } state_e;

    localparam logic [OFIFO_AW:0] PtrOne = (OFIFO_AW+1)'(1);

    state_e              state_q, state_d;
    logic [23:0]         base_q, base_d;
    logic [12:0]         sig_q, sig_d;
    logic [3:0]          held_n;
    logic                emit;
    logic [31:0]         word;

    logic [31:0]         mem_q [OFIFO_DEPTH];
    logic [OFIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [OFIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                empty, full, push, pop;

    always_comb begin
        held_n = 4'd0;
        unique case (state_q)
            StBase1: held_n = 4'd1;
            StBase2: held_n = 4'd2;
            StBase3: held_n = 4'd3;
            StBase4: held_n = 4'd4;
            default: held_n = 4'd0;
        endcase
    end

    // Held slots are cleared whenever a word is emitted, so unused fields are already zero.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        sig_d   = sig_q;
        emit    = 1'b0;
        word    = '0;
        unique case (state_q)
            StEmpty: begin
                if (baseline_flag) begin
                    base_d  = {18'd0, DATA_to_enc[5:0]};
                    state_d = StBase1;
                end else begin
                    sig_d   = DATA_to_enc;
                    state_d = StSig1;
                end
            end
            StBase1, StBase2, StBase3, StBase4: begin
                if (baseline_flag && state_q == StBase4) begin
                    emit    = 1'b1;
                    word    = {2'b01, DATA_to_enc[5:0], base_q};
                    base_d  = '0;
                    state_d = StEmpty;
                end else if (baseline_flag) begin
                    base_d[6*held_n +: 6] = DATA_to_enc[5:0];
                    state_d = state_e'(state_q + 3'd1);
                end else begin
                    emit    = 1'b1;
                    word    = {4'b1101, held_n, base_q};
                    base_d  = '0;
                    sig_d   = DATA_to_enc;
                    state_d = StSig1;
                end
            end
            StSig1: begin
                emit    = 1'b1;
                word    = {6'b001010, DATA_to_enc, sig_q};
                sig_d   = '0;
                state_d = StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StEmpty;
            base_q  <= '0;
            sig_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            sig_q   <= sig_d;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[OFIFO_AW] != rd_ptr_q[OFIFO_AW]) &&
                     (wr_ptr_q[OFIFO_AW-1:0] == rd_ptr_q[OFIFO_AW-1:0]);
        pop        = !empty && DATA32_ready;
        push       = emit && (!full || pop);
        wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
        overflow_d = overflow_q || (emit && full && !pop);
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(OFIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[OFIFO_AW-1:0]] <= word;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    assign DATA32        = mem_q[rd_ptr_q[OFIFO_AW-1:0]];
    assign DATA32_valid  = !empty;
    assign fifo_level    = wr_ptr_q - rd_ptr_q;
    assign fifo_overflow = overflow_q;

endmodule
